// File: rtl/bus_master_port_pkg.sv
// Shared definitions for the system-bus initiator port: state encoding, mode values, default widths.
package bus_master_port_pkg;

    localparam int unsigned ADDR_WIDTH_DEF        = 16;
    localparam int unsigned DEVICE_ADDR_WIDTH_DEF = 4;
    localparam int unsigned DATA_WIDTH_DEF        = 8;
    localparam int unsigned ACK_TIMEOUT_DEF       = 4;

    localparam logic MODE_READ  = 1'b0;
    localparam logic MODE_WRITE = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DEV   = 3'd1,
        ST_ACKW  = 3'd2,
        ST_ADDR  = 3'd3,
        ST_WDATA = 3'd4,
        ST_RDATA = 3'd5,
        ST_SWAIT = 3'd6
    } state_e;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/bus_master_port_if.sv
// Serial system-bus signals between the initiator port and the decoder/slaves.
interface bus_master_port_if;

    logic mwdata;
    logic mvalid;
    logic mmode;
    logic ack;
    logic sready;
    logic srdata;
    logic svalid;

    modport master (
        output mwdata, mvalid, mmode,
        input  ack, sready, srdata, svalid
    );

    modport slave (
        input  mwdata, mvalid, mmode,
        output ack, sready, srdata, svalid
    );

endinterface

// File: rtl/bus_master_port_piso_shift.sv
// Parallel-in serial-out shifter, LSB first; the shift register LSB is the registered serial bit.
module piso_shift #(
    parameter int unsigned W  = 12,
    parameter int unsigned CW = 5
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    input  logic          load_i,
    input  logic [W-1:0]  data_i,
    input  logic [CW-1:0] len_i,
    input  logic          shift_i,
    output logic          ser_o,
    output logic          last_c_o
);

    logic [W-1:0]  sh_q, sh_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] len_q, len_d;

    // Zeros shift in behind the field so the line idles low once a field is sent.
    always_comb begin
        sh_d  = sh_q;
        cnt_d = cnt_q;
        len_d = len_q;
        if (load_i) begin
            sh_d  = data_i;
            cnt_d = '0;
            len_d = len_i;
        end else if (shift_i) begin
            sh_d  = sh_q >> 1;
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            sh_q  <= '0;
            cnt_q <= '0;
            len_q <= '0;
        end else begin
            sh_q  <= sh_d;
            cnt_q <= cnt_d;
            len_q <= len_d;
        end
    end

    assign ser_o    = sh_q[0];
    assign last_c_o = (cnt_q == len_q - CW'(1));

endmodule

// File: rtl/bus_master_port.sv
// System-bus initiator port: serialises device address, memory address and write data,
// collects serial read data, and reports completion/no-ack back to the local master.
module bus_master_port
    import bus_master_port_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH        = ADDR_WIDTH_DEF,
    parameter int unsigned DEVICE_ADDR_WIDTH = DEVICE_ADDR_WIDTH_DEF,
    parameter int unsigned DATA_WIDTH        = DATA_WIDTH_DEF,
    parameter int unsigned ACK_TIMEOUT       = ACK_TIMEOUT_DEF
) (
    input  logic                                  clk,
    input  logic                                  rstn,
    input  logic                                  dreq,
    input  logic                                  dmode,
    input  logic [DEVICE_ADDR_WIDTH-1:0]          ddev_addr,
    input  logic [ADDR_WIDTH-DEVICE_ADDR_WIDTH-1:0] dmem_addr,
    input  logic [DATA_WIDTH-1:0]                 dwdata,
    output logic                                  dready,
    output logic                                  ddone,
    output logic                                  derr,
    output logic [DATA_WIDTH-1:0]                 drdata,
    bus_master_port_if.master                     bus
);

    localparam int unsigned MEM_W   = ADDR_WIDTH - DEVICE_ADDR_WIDTH;
    localparam int unsigned SHIFT_W = max3(DEVICE_ADDR_WIDTH, MEM_W, DATA_WIDTH);
    localparam int unsigned CNT_W   = $clog2(max3(SHIFT_W, ACK_TIMEOUT, 2)) + 1;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [MEM_W-1:0]        mem_q, mem_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    mode_q, mode_d;
    logic [DATA_WIDTH-1:0]   drdata_q, drdata_d;
    logic                    dready_q, dready_d;
    logic                    ddone_q, ddone_d;
    logic                    derr_q, derr_d;
    logic                    mvalid_q, mvalid_d;
    logic                    mmode_q, mmode_d;

    logic                    piso_load;
    logic [SHIFT_W-1:0]      piso_data;
    logic [CNT_W-1:0]        piso_len;
    logic                    piso_shift;
    logic                    piso_ser;
    logic                    piso_last_c;

    // One shifter serves all three outgoing fields; each field is loaded as the previous ends.
    piso_shift #(
        .W  (SHIFT_W),
        .CW (CNT_W)
    ) u_piso (
        .clk_i    (clk),
        .rstn_i   (rstn),
        .load_i   (piso_load),
        .data_i   (piso_data),
        .len_i    (piso_len),
        .shift_i  (piso_shift),
        .ser_o    (piso_ser),
        .last_c_o (piso_last_c)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mem_d      = mem_q;
        data_d     = data_q;
        mode_d     = mode_q;
        drdata_d   = drdata_q;
        ddone_d    = 1'b0;
        derr_d     = 1'b0;
        piso_load  = 1'b0;
        piso_data  = '0;
        piso_len   = '0;
        piso_shift = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (dreq) begin
                    state_d   = ST_DEV;
                    mem_d     = dmem_addr;
                    data_d    = dwdata;
                    mode_d    = dmode;
                    drdata_d  = '0;
                    piso_load = 1'b1;
                    piso_data = SHIFT_W'(ddev_addr);
                    piso_len  = CNT_W'(DEVICE_ADDR_WIDTH);
                end
            end
            ST_DEV: begin
                piso_shift = 1'b1;
                if (piso_last_c) state_d = ST_ACKW;
            end
            ST_ACKW: begin
                // ack takes priority over an expiring timeout in the same cycle.
                if (bus.ack) begin
                    state_d   = ST_ADDR;
                    piso_load = 1'b1;
                    piso_data = SHIFT_W'(mem_q);
                    piso_len  = CNT_W'(MEM_W);
                end else if (cnt_q == CNT_W'(ACK_TIMEOUT - 1)) begin
                    state_d = ST_IDLE;
                    ddone_d = 1'b1;
                    derr_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_ADDR: begin
                if (piso_last_c && mode_q == MODE_WRITE) begin
                    state_d   = ST_WDATA;
                    piso_load = 1'b1;
                    piso_data = SHIFT_W'(data_q);
                    piso_len  = CNT_W'(DATA_WIDTH);
                end else begin
                    piso_shift = 1'b1;
                    if (piso_last_c) state_d = ST_RDATA;
                end
            end
            ST_WDATA: begin
                piso_shift = 1'b1;
                if (piso_last_c) state_d = ST_SWAIT;
            end
            ST_RDATA: begin
                if (bus.svalid) begin
                    drdata_d = drdata_q | (DATA_WIDTH'(bus.srdata) << cnt_q);
                    if (cnt_q == CNT_W'(DATA_WIDTH - 1)) state_d = ST_SWAIT;
                    else                                  cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            ST_SWAIT: begin
                if (bus.sready) begin
                    state_d = ST_IDLE;
                    ddone_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_d != state_q) cnt_d = '0;

        // Bus/status outputs are registered from the state being entered.
        dready_d = (state_d == ST_IDLE);
        mvalid_d = (state_d == ST_DEV) || (state_d == ST_ADDR) || (state_d == ST_WDATA);
        mmode_d  = (state_d != ST_IDLE) && mode_d;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            mem_q    <= '0;
            data_q   <= '0;
            mode_q   <= 1'b0;
            drdata_q <= '0;
            dready_q <= 1'b1;
            ddone_q  <= 1'b0;
            derr_q   <= 1'b0;
            mvalid_q <= 1'b0;
            mmode_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mem_q    <= mem_d;
            data_q   <= data_d;
            mode_q   <= mode_d;
            drdata_q <= drdata_d;
            dready_q <= dready_d;
            ddone_q  <= ddone_d;
            derr_q   <= derr_d;
            mvalid_q <= mvalid_d;
            mmode_q  <= mmode_d;
        end
    end

    assign dready     = dready_q;
    assign ddone      = ddone_q;
    assign derr       = derr_q;
    assign drdata     = drdata_q;
    assign bus.mwdata = piso_ser;
    assign bus.mvalid = mvalid_q;
    assign bus.mmode  = mmode_q;

endmodule
